// File: rtl/alu_result_stage_if.sv
// Bus bundle for the EX/MEM result stage: upstream beat, downstream beat,
// flush and PC redirect. The stage is the slave; its environment is the master.
interface alu_result_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      alu_zero;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [ADDR_WIDTH-1:0]     imm;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic                      reg_write;
  logic                      mem_read;
  logic                      mem_write;
  logic [1:0]                branch_type;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_alu_result;
  logic [DATA_WIDTH-1:0]     out_store_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd_addr;
  logic                      out_reg_write;
  logic                      out_mem_read;
  logic                      out_mem_write;
  logic                      redirect_valid;
  logic [ADDR_WIDTH-1:0]     redirect_pc;

  modport master (
    output in_valid, alu_result, alu_zero, pc, imm, store_data, rd_addr,
           reg_write, mem_read, mem_write, branch_type, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_rd_addr,
           out_reg_write, out_mem_read, out_mem_write, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, pc, imm, store_data, rd_addr,
           reg_write, mem_read, mem_write, branch_type, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_rd_addr,
           out_reg_write, out_mem_read, out_mem_write, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/alu_result_stage.sv
// EX/MEM register stage: resolves branches into a one-cycle PC redirect and
// hands beats downstream through a 2-entry (main + skid) buffer.
module alu_result_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } beat_t;

  beat_t beat_p0;
  beat_t main_p1;
  beat_t skid_p1;
  logic  vld_main_p1;
  logic  vld_skid_p1;
  logic  accept;
  logic  drain;
  logic  taken_p0;

  function automatic logic branch_taken(input logic [1:0] kind, input logic zero);
    case (kind)
      2'b01:   branch_taken = zero;
      2'b10:   branch_taken = ~zero;
      2'b11:   branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Stage p0: incoming beat, with writes to x0 suppressed before storage
  always_comb begin
    beat_p0.alu_result = bus.alu_result;
    beat_p0.store_data = bus.store_data;
    beat_p0.rd_addr    = bus.rd_addr;
    beat_p0.reg_write  = bus.reg_write & (bus.rd_addr != '0);
    beat_p0.mem_read   = bus.mem_read;
    beat_p0.mem_write  = bus.mem_write;
  end

  assign accept   = bus.in_valid & ~vld_skid_p1 & ~bus.flush;
  assign drain    = vld_main_p1 & bus.out_ready;
  assign taken_p0 = branch_taken(bus.branch_type, bus.alu_zero);

  // Stage p1: main/skid entries; skid refills main first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_main_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (bus.flush) begin
      vld_main_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (!vld_main_p1 || drain) begin
      if (vld_skid_p1) begin
        main_p1     <= skid_p1;
        vld_main_p1 <= 1'b1;
        vld_skid_p1 <= accept;
        if (accept) skid_p1 <= beat_p0;
      end else begin
        vld_main_p1 <= accept;
        if (accept) main_p1 <= beat_p0;
      end
    end else if (accept) begin
      skid_p1     <= beat_p0;
      vld_skid_p1 <= 1'b1;
    end
  end

  // Redirect is raised at acceptance, independent of downstream stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.redirect_valid <= accept & taken_p0;
      if (accept && taken_p0) bus.redirect_pc <= bus.pc + bus.imm;
    end
  end

  assign bus.in_ready       = ~vld_skid_p1;
  assign bus.out_valid      = vld_main_p1;
  assign bus.out_alu_result = main_p1.alu_result;
  assign bus.out_store_data = main_p1.store_data;
  assign bus.out_rd_addr    = main_p1.rd_addr;
  assign bus.out_reg_write  = main_p1.reg_write;
  assign bus.out_mem_read   = main_p1.mem_read;
  assign bus.out_mem_write  = main_p1.mem_write;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: a 2-deep FIFO occupancy model plus a
// timed redirect queue, driven by directed and random beats.
module tb_alu_result_stage;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic last_acc;
  logic [31:0] last_pc;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;
  typedef struct {
    int          when;
    logic [31:0] pc;
  } red_t;

  exp_t q[$];
  red_t rq[$];

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the model at every falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rv;
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
      exp_rv = (rq.size() > 0) && (rq[0].when == cyc);
      if (exp_rv) begin
        last_pc = rq[0].pc;
        void'(rq.pop_front());
      end
      chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, exp_rv});
      chk("redirect_pc", bus.redirect_pc, last_pc);
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_alu_result", bus.out_alu_result, e.res);
        chk("out_store_data", bus.out_store_data, e.sd);
        chk("out_rd_addr", {27'b0, bus.out_rd_addr}, {27'b0, e.rd});
        chk("out_reg_write", {31'b0, bus.out_reg_write}, {31'b0, e.rw});
        chk("out_mem_read", {31'b0, bus.out_mem_read}, {31'b0, e.mr});
        chk("out_mem_write", {31'b0, bus.out_mem_write}, {31'b0, e.mw});
      end
    end
  end

  // Records acceptance into the scoreboard, then advances to posedge+1
  task automatic tick();
    @(negedge clk);
    #1;
    last_acc = 1'b0;
    if (rst_n && bus.in_valid && bus.in_ready && !bus.flush) begin
      exp_t e;
      logic tk;
      last_acc = 1'b1;
      e.res = bus.alu_result;
      e.sd  = bus.store_data;
      e.rd  = bus.rd_addr;
      e.rw  = bus.reg_write && (bus.rd_addr != 5'd0);
      e.mr  = bus.mem_read;
      e.mw  = bus.mem_write;
      q.push_back(e);
      case (bus.branch_type)
        2'b01:   tk = bus.alu_zero;
        2'b10:   tk = !bus.alu_zero;
        2'b11:   tk = 1'b1;
        default: tk = 1'b0;
      endcase
      if (tk) begin
        red_t r;
        r.when = cyc + 1;
        r.pc   = bus.pc + bus.imm;
        rq.push_back(r);
      end
    end
    if (rst_n && bus.flush) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] res, input logic zero, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic [1:0] bt);
    bus.in_valid    = 1'b1;
    bus.alu_result  = res;
    bus.alu_zero    = zero;
    bus.pc          = pc;
    bus.imm         = imm;
    bus.store_data  = sd;
    bus.rd_addr     = rd;
    bus.reg_write   = rw;
    bus.mem_read    = mr;
    bus.mem_write   = mw;
    bus.branch_type = bt;
  endtask

  // Holds the current beat until accepted (bounded)
  task automatic hold_until_accepted(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] res, input logic zero, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                      input logic [1:0] bt);
    set_beat(res, zero, pc, imm, res ^ 32'h5A5A_0000, rd, rw, res[0], res[1], bt);
    hold_until_accepted("send");
  endtask

  initial begin
    rst_n = 1'b0;
    last_pc = 32'h0;
    bus.in_valid = 1'b0; bus.alu_result = '0; bus.alu_zero = 1'b0; bus.pc = '0;
    bus.imm = '0; bus.store_data = '0; bus.rd_addr = '0; bus.reg_write = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.branch_type = 2'b00;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_out_alu_result", bus.out_alu_result, 32'd0);
    chk("rst_out_store_data", bus.out_store_data, 32'd0);
    rst_n = 1'b1;

    // Taken BEQ with negative offset
    send(32'h11, 1'b1, 32'h100, 32'hFFFF_FFF0, 5'd3, 1'b0, 2'b01);
    chk("beq_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("beq_redirect_pc", bus.redirect_pc, 32'h0000_00F0);
    tick();
    chk("beq_pulse_one_cycle", {31'b0, bus.redirect_valid}, 32'd0);
    // BNE not taken, then JAL wrapping past 2^32
    send(32'h22, 1'b1, 32'h200, 32'h40, 5'd4, 1'b0, 2'b10);
    send(32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFF8, 32'h10, 5'd1, 1'b1, 2'b11);
    chk("jal_redirect_pc", bus.redirect_pc, 32'h0000_0008);
    tick();

    // Backpressure: 4 beats with out_ready low, then release
    bus.out_ready = 1'b0;
    send(32'd1, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00);
    send(32'd2, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00);
    set_beat(32'd3, 1'b0, 32'h0, 32'h0, 32'd3, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    tick();
    bus.out_ready = 1'b1;
    hold_until_accepted("bp3");
    send(32'd4, 1'b0, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00);
    repeat (4) tick();

    // x0 destination suppresses the register write
    send(32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00);
    repeat (2) tick();

    // Flush with both entries full and a taken BEQ presented
    bus.out_ready = 1'b0;
    send(32'hA1, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00);
    send(32'hA2, 1'b0, 32'h0, 32'h0, 5'd10, 1'b1, 2'b00);
    set_beat(32'hA3, 1'b1, 32'h300, 32'h8, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    // Flush with room to accept: the taken BEQ must still be discarded
    send(32'hB1, 1'b0, 32'h0, 32'h0, 5'd11, 1'b1, 2'b00);
    set_beat(32'hB2, 1'b1, 32'h400, 32'h8, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush2_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      set_beat($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset with both entries full and a redirect in flight
    bus.out_ready = 1'b0;
    send(32'hC1, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1, 2'b00);
    send(32'hC2, 1'b0, 32'h500, 32'h20, 5'd13, 1'b1, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("arst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("arst_out_alu_result", bus.out_alu_result, 32'd0);
    chk("arst_out_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    q.delete();
    rq.delete();
    last_pc = 32'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'hD1, 1'b1, 32'h600, 32'h4, 5'd14, 1'b1, 2'b01);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- EX/MEM boundary register stage directly downstream of the ALU in the RISC-V CPU.
- Captures the ALU result and zero flag with the accompanying control bits, resolves conditional branches and jumps, and issues a one-cycle PC redirect.
- Passes each beat to the memory stage through a 2-entry skid buffer with valid/ready handshakes on both sides, so downstream backpressure never drops a beat.

Parameters:
- DATA_WIDTH, 32, width of ALU result and store data.
- ADDR_WIDTH, 32, width of PC, immediate and redirect target.
- REG_ADDR_WIDTH, 5, width of destination register index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- alu_result  in  DATA_WIDTH  ALU output. For JAL, upstream supplies pc+4 here.
- alu_zero  in  1  ALU zero flag.
- pc  in  ADDR_WIDTH  PC of the instruction.
- imm  in  ADDR_WIDTH  sign-extended branch/jump offset.
- store_data  in  DATA_WIDTH  rs2 value for stores.
- rd_addr  in  REG_ADDR_WIDTH  destination register.
- reg_write, mem_read, mem_write  in  1 each  control bits.
- branch_type  in  2  00 none, 01 BEQ, 10 BNE, 11 JAL.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_alu_result  out  DATA_WIDTH  registered result.
- out_store_data  out  DATA_WIDTH  registered store data.
- out_rd_addr  out  REG_ADDR_WIDTH  registered rd.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control bits.
- redirect_valid  out  1  one-cycle taken-branch pulse.
- redirect_pc  out  ADDR_WIDTH  branch/jump target.

Behaviour:
- Reset (rst_n low, asynchronous): main and skid entries invalid; all out_* data and control outputs 0; redirect_valid 0; redirect_pc 0; in_ready 1.
- Accept: a beat is accepted when in_valid & in_ready, and flush is low. Downstream transfer occurs when out_valid & out_ready.
- in_ready = !skid_valid, driven from a register only (no combinational path from out_ready).
- Entry movement per clock edge:
  - Main empty, or main draining this cycle: an accepted beat loads into main.
  - Main full and not draining: an accepted beat loads into skid.
  - Main drains while skid is valid: skid moves to main, and skid becomes free.
  - A beat accepted in the same cycle as a skid-to-main move loads into skid.
- Ordering: strict FIFO order is preserved across main and skid.
- Latency: 1 cycle from acceptance to out_valid when unstalled. Sustained throughput is 1 beat per cycle.
- out_valid = main_valid. All out_* fields reflect the main entry and stay stable while out_valid & !out_ready.
- Branch resolution at acceptance: taken = (BEQ & alu_zero) | (BNE & !alu_zero) | JAL.
- Redirect timing:
  - redirect_valid pulses for exactly 1 cycle, on the cycle after acceptance of a taken beat.
  - redirect_pc = (pc + imm) mod 2^ADDR_WIDTH, registered with the pulse. redirect_pc holds its last value otherwise.
  - Redirect fires independently of downstream stall.
- Branch beats still flow downstream. BEQ/BNE beats carry reg_write=0 from upstream; the stage does not alter this.
- x0 rule: if rd_addr == 0, the stored reg_write bit is forced to 0.
- Flush (synchronous, highest priority):
  - At the next edge, main and skid are invalidated and any same-cycle input beat is discarded.
  - No redirect is generated for a beat discarded by flush.
  - A redirect pulse already registered in the flush cycle still completes.
  - in_ready returns to 1 the cycle after flush.
- Reset asserted mid-operation clears everything immediately; no partial beat or pulse survives.

Test Plan:
- Reset, then BEQ accepted: in_valid=1, branch_type=01, alu_zero=1, pc=0x100, imm=0xFFFFFFF0 -> next cycle redirect_valid=1 for one cycle, redirect_pc=0x0F0, out_valid=1.
- BNE with alu_zero=1 -> no redirect. JAL with pc=0xFFFFFFF8, imm=0x10 -> redirect_pc=0x00000008 (wraps).
- Backpressure: 4 back-to-back beats with results 1, 2, 3, 4, out_ready held 0 -> beat 1 in main, beat 2 in skid, in_ready=0 from cycle 3. Release out_ready -> outputs 1, 2, 3, 4 in order, none lost or duplicated.
- rd_addr=0 with reg_write=1, alu_result=0xDEADBEEF -> out_reg_write=0, out_alu_result=0xDEADBEEF.
- Both entries full, flush=1 with in_valid=1 carrying a taken BEQ -> next cycle out_valid=0, in_ready=1, redirect_valid=0.
- rst_n dropped asynchronously mid-clock with both entries full -> out_valid, redirect_valid and outputs 0 immediately, in_ready=1.
